// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory-wait
// freezes and halt/resume, plus a saturating lost-cycle counter.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_halt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    input  logic                  resume,
    input  logic                  stat_clr,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_count
);

    // state  | meaning
    // RUN    | normal issue; stalls on load-use, flushes on taken branch
    // FLUSH  | squashing remaining wrong-path fetches, flush_cnt more after this
    // HALT   | HALT parked in ID until resume
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic [1:0] flush_cnt;
    logic       resume_flush;
    logic       load_use;
    logic       lost_cycle;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        halted         = 1'b0;
        if (!reset) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_busy) begin
                        pc_write_en = 1'b0;
                    end else if (resume_flush || ex_branch_taken) begin
                        // drop the parked HALT, or the wrong-path fetch
                        pc_write_en  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use || id_halt) begin
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_write_en    = 1'b1;
                        if_id_write_en = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!mem_busy) begin
                        pc_write_en  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                ST_HALT: begin
                    id_ex_bubble = 1'b1;
                    halted       = 1'b1;
                end
                default: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            endcase
        end
    end

    assign lost_cycle = (state != ST_HALT) && (!pc_write_en || if_id_flush);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_RUN;
            flush_cnt    <= 2'd0;
            resume_flush <= 1'b0;
            stall_count  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!mem_busy) begin
                        if (resume_flush) begin
                            resume_flush <= 1'b0;
                        end else if (ex_branch_taken) begin
                            if (FLUSH_CYCLES > 1) begin
                                state     <= ST_FLUSH;
                                flush_cnt <= FLUSH_INIT;
                            end
                        end else if (!load_use && id_halt) begin
                            state <= ST_HALT;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!mem_busy) begin
                        if (flush_cnt == 2'd0) begin
                            state <= ST_RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 2'd1;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state        <= ST_RUN;
                        resume_flush <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase

            if (stat_clr) begin
                stall_count <= '0;
            end else if (lost_cycle && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=3, CNT_W=4) with a
// cycle-level reference model checked on every negedge.
module tb_pipe_hazard_ctrl;

    localparam int RAW = 3;
    localparam int FC  = 3;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [RAW-1:0] id_rs1, id_rs2, ex_rd;
    logic           id_uses_rs1, id_uses_rs2, id_halt;
    logic           ex_mem_read, ex_branch_taken, mem_busy, resume, stat_clr;
    logic           pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, halted;
    logic [CW-1:0]  stall_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_flush_left = 0;
    bit m_halt = 0;
    bit m_drop = 0;
    int m_cnt  = 0;

    pipe_hazard_ctrl #(.REG_ADDR_W(RAW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .resume(resume), .stat_clr(stat_clr),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_load_use();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    // expected outputs {pc, wr, flush, bubble, halted} and which of wr/bubble are defined
    function automatic void model_out(output bit pc, output bit wr, output bit fl,
                                      output bit bub, output bit hl,
                                      output bit chk_wr, output bit chk_bub);
        pc = 0; wr = 0; fl = 0; bub = 0; hl = 0; chk_wr = 1; chk_bub = 1;
        if (!reset) begin
            fl = 1; bub = 1;
        end else if (m_halt) begin
            bub = 1; hl = 1;
        end else if (mem_busy) begin
            pc = 0;
        end else if (m_drop) begin
            pc = 1; fl = 1; bub = 1; chk_bub = 0;
        end else if (m_flush_left > 0 || ex_branch_taken) begin
            pc = 1; fl = 1; bub = 1;
        end else if (m_load_use() || id_halt) begin
            bub = 1;
        end else begin
            pc = 1; wr = 1;
        end
        if (fl) chk_wr = (!reset);
    endfunction

    always @(posedge clk) begin
        bit pc, wr, fl, bub, hl, cw, cb;
        model_out(pc, wr, fl, bub, hl, cw, cb);
        if (!reset) begin
            m_flush_left = 0; m_halt = 0; m_drop = 0; m_cnt = 0;
        end else begin
            if (stat_clr) m_cnt = 0;
            else if (!m_halt && (!pc || fl) && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (m_halt) begin
                if (resume) begin m_halt = 0; m_drop = 1; end
            end else if (!mem_busy) begin
                if (m_drop) m_drop = 0;
                else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
                else if (ex_branch_taken) m_flush_left = FC - 1;
                else if (!m_load_use() && id_halt) m_halt = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit pc, wr, fl, bub, hl, cw, cb;
        model_out(pc, wr, fl, bub, hl, cw, cb);
        chk("pc_write_en", 32'(pc_write_en), 32'(pc));
        chk("if_id_flush", 32'(if_id_flush), 32'(fl));
        chk("halted", 32'(halted), 32'(hl));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        if (cw) chk("if_id_write_en", 32'(if_id_write_en), 32'(wr));
        if (cb) chk("id_ex_bubble", 32'(id_ex_bubble), 32'(bub));
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_halt = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_busy = 0; resume = 0; stat_clr = 0;
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    endtask

    task automatic clear_stats();
        idle(); stat_clr = 1; tick(); stat_clr = 0;
    endtask

    initial begin
        reset = 0;
        idle();
        tick(2);
        chk("rst_pc", 32'(pc_write_en), 0);
        chk("rst_flush", 32'(if_id_flush), 1);
        chk("rst_bubble", 32'(id_ex_bubble), 1);
        chk("rst_cnt", 32'(stall_count), 0);
        reset = 1;
        tick();

        // load-use via rs1
        set_load_use(); #1;
        chk("lu_pc", 32'(pc_write_en), 0);
        chk("lu_wr", 32'(if_id_write_en), 0);
        chk("lu_bubble", 32'(id_ex_bubble), 1);
        tick(); idle(); #1;
        chk("lu_cnt", 32'(stall_count), 1);
        // ex_rd = 0 is never a hazard
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; #1;
        chk("rd0_pc", 32'(pc_write_en), 1);
        tick();
        // rs2 match, then rs2 unused, then no load
        idle(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 5; id_uses_rs2 = 1; tick();
        id_uses_rs2 = 0; tick();
        id_uses_rs1 = 1; ex_mem_read = 0; tick();
        chk("lu_cnt2", 32'(stall_count), 2);
        clear_stats();
        chk("clr_cnt", 32'(stall_count), 0);

        // branch: three flush cycles
        ex_branch_taken = 1;
        for (int i = 0; i < FC; i++) begin
            #1;
            chk("br_flush", 32'(if_id_flush), 1);
            chk("br_pc", 32'(pc_write_en), 1);
            tick();
            idle();
            set_load_use(); id_halt = (i == 1);  // ignored while flushing
        end
        idle(); #1;
        chk("br_done", 32'(if_id_flush), 0);
        chk("br_cnt", 32'(stall_count), 3);
        clear_stats();

        // mem_busy inside a flush
        ex_branch_taken = 1; tick();
        idle(); tick();
        mem_busy = 1; ex_branch_taken = 1; #1;
        chk("mb_pc", 32'(pc_write_en), 0);
        chk("mb_flush", 32'(if_id_flush), 0);
        tick(2);
        idle(); #1;
        chk("mb_flush3", 32'(if_id_flush), 1);
        tick(); #1;
        chk("mb_done", 32'(if_id_flush), 0);
        chk("mb_cnt", 32'(stall_count), 5);
        clear_stats();

        // priority: freeze, then branch over load-use
        mem_busy = 1; ex_branch_taken = 1; set_load_use(); #1;
        chk("pri_pc", 32'(pc_write_en), 0);
        chk("pri_bub", 32'(id_ex_bubble), 0);
        tick();
        mem_busy = 0; #1;
        chk("pri_br", 32'(if_id_flush), 1);
        tick(); idle(); tick(3);
        clear_stats();

        // halt and resume
        id_halt = 1; tick();
        idle(); mem_busy = 1; ex_branch_taken = 1; set_load_use(); #1;
        chk("halt_hl", 32'(halted), 1);
        tick(3);
        chk("halt_cnt", 32'(stall_count), 1);
        resume = 1; tick();
        idle(); #1;
        chk("res_hl", 32'(halted), 0);
        chk("res_flush", 32'(if_id_flush), 1);
        chk("res_pc", 32'(pc_write_en), 1);
        tick(); #1;
        chk("res_norm", 32'(if_id_flush), 0);
        chk("res_cnt", 32'(stall_count), 2);
        // resume followed by a memory wait in the drop cycle
        id_halt = 1; tick(); idle(); tick(2);
        resume = 1; tick(); resume = 0; mem_busy = 1; tick(); mem_busy = 0; tick(2);
        clear_stats();

        // saturation and clear
        set_load_use(); tick(20);
        chk("sat_cnt", 32'(stall_count), CMAX);
        idle(); stat_clr = 1; set_load_use(); tick(); idle();
        chk("sat_clr", 32'(stall_count), 0);

        // reset mid-flush and mid-halt
        ex_branch_taken = 1; tick(); idle();
        reset = 0; #1;
        chk("rf_pc", 32'(pc_write_en), 0);
        chk("rf_wr", 32'(if_id_write_en), 0);
        chk("rf_flush", 32'(if_id_flush), 1);
        chk("rf_bub", 32'(id_ex_bubble), 1);
        tick(); reset = 1; #1;
        chk("rf_run", 32'(if_id_flush), 0);
        chk("rf_cnt", 32'(stall_count), 0);
        tick();
        id_halt = 1; tick(); idle();
        reset = 0; #1;
        chk("rh_hl", 32'(halted), 0);
        tick(); reset = 1; #1;
        chk("rh_run", 32'(pc_write_en), 1);
        chk("rh_noflush", 32'(if_id_flush), 0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage 16-bit core. Each cycle it decides whether the PC and the IF/ID register advance, hold, or flush, and whether a bubble goes into ID/EX. It covers load-use stalls, taken-branch flushes, data-memory wait freezes and a halt/resume mode. It also keeps a saturating count of lost cycles for performance debug.

## Interface
- REG_ADDR_W, 3, register-address width; register 0 is hardwired zero.
- FLUSH_CYCLES, 1, wrong-path cycles squashed per taken branch; legal range 1..4.
- CNT_W, 16, width of stall_count.

- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; 0 = reset asserted.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads that source.
- id_halt  in  1  the ID instruction is HALT.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- ex_branch_taken  in  1  the EX branch is resolved taken; PC mux selection is done outside this block.
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- resume  in  1  single-cycle pulse that leaves HALT.
- stat_clr  in  1  synchronous clear of stall_count.
- pc_write_en  out  1  PC loads its next value.
- if_id_write_en  out  1  IF/ID captures a new instruction and PC+1.
- if_id_flush  out  1  IF/ID loads zero (NOP); overrides if_id_write_en.
- id_ex_bubble  out  1  ID/EX loads a NOP instead of the decoded instruction.
- halted  out  1  the controller is in HALT.
- stall_count  out  CNT_W  lost-cycle counter.

## Operation
- States: RUN, FLUSH, HALT. There is also a flush_cnt register of 2 bits.
- Outputs are Mealy: they are combinational from the state and the current inputs.
- While reset=0, outputs are forced to pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_bubble=1, halted=0.
- Load-use hazard: load_use = ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, evaluated in priority order:
  1. mem_busy: freeze. pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_bubble=0. State is held.
  2. ex_branch_taken: pc_write_en=1, if_id_flush=1, id_ex_bubble=1. If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-2.
  3. load_use: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. Stay in RUN; the hazard clears by itself next cycle.
  4. id_halt: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. Go to HALT.
  5. Otherwise: pc_write_en=1, if_id_write_en=1, no flush, no bubble.
- FLUSH:
  - mem_busy freezes exactly as in RUN, and flush_cnt holds.
  - Otherwise: pc_write_en=1, if_id_flush=1, id_ex_bubble=1. If flush_cnt==0 go to RUN, else decrement flush_cnt.
  - ex_branch_taken, load_use and id_halt are ignored, because EX only holds bubbles.
- HALT:
  - pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_bubble=1, halted=1. All ex_* and id_* inputs and mem_busy are ignored.
  - resume=1 returns to RUN on the next edge. The held ID instruction (the HALT) is then dropped by one forced if_id_flush cycle in the first RUN cycle, with pc_write_en=1 in that cycle. A 1-bit resume_flush flag is required for this.
- stall_count:
  - Increments by 1 on each edge where reset=1, state≠HALT, and (pc_write_en=0 or if_id_flush=1).
  - Saturates at 2^CNT_W−1.
  - stat_clr wins over increment and sets the count to 0.
- Reset (reset=0 at an edge): state=RUN, flush_cnt=0, resume_flush=0, stall_count=0. Reset taken in the middle of a FLUSH or HALT aborts it immediately.

## Timing
- All control decisions are made in the same cycle as their inputs. Their effect appears in the pipeline registers at the next posedge.
- Load-use penalty: exactly 1 cycle.
- Taken-branch penalty: FLUSH_CYCLES cycles.
- mem_busy: adds exactly one frozen cycle per cycle it is high, in any non-HALT state.
- HALT: entry takes effect 1 edge after id_halt is seen. Exit takes effect 1 edge after resume.
- State, flush_cnt and stall_count change only on posedge clk.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3, id_uses_rs1=1 for one cycle. Required: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 that cycle; stall_count goes 0→1. With ex_rd=0 instead: no stall.
- Branch with FLUSH_CYCLES=3: ex_branch_taken pulse. Required: if_id_flush=1 and id_ex_bubble=1 for 3 consecutive cycles with pc_write_en=1, then RUN; stall_count=3.
- mem_busy high for 2 cycles in the middle of a FLUSH_CYCLES=3 flush. Required: outputs frozen for those 2 cycles; total flush cycles still 3; stall_count=5.
- Priority: mem_busy, ex_branch_taken and load_use all 1 in the same cycle. Required: freeze only. Next cycle with mem_busy=0: branch flush wins over load_use.
- Halt and resume: id_halt=1. Required: halted=1 from the next cycle; stall_count does not increment during HALT. After a resume pulse: one if_id_flush=1 cycle with pc_write_en=1, then normal flow.
- Saturation and clear, with CNT_W=4: hold load_use for 20 cycles. Required: stall_count stops at 15. stat_clr then gives 0. Reset asserted mid-FLUSH: state=RUN and all forced-reset output values apply.
